// File: rtl/game_tick_pkg.sv
// ----------------------------------------------------------------------------
// game_tick_pkg
// Shared definitions for the LED catcher game tick scheduler:
//   - run_state_t  : run-state encoding (IDLE / RUN / PAUSE)
//   - DEF_*        : default timing constants (100 MHz clk_in)
//   - LEVEL_W      : width of the applied level count
//   - LEVEL_MAX    : saturation value of the level count
// ----------------------------------------------------------------------------
package game_tick_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } run_state_t;

    localparam int unsigned DEF_BASE_PERIOD = 300_000_000;  // 3 s at 100 MHz
    localparam int unsigned DEF_MIN_PERIOD  = 50_000_000;
    localparam int unsigned DEF_STEP        = 25_000_000;
    localparam int unsigned DEF_WARN_CYCLES = 50_000_000;
    localparam int          DEF_CNT_W       = 33;

    localparam int                 LEVEL_W   = 4;
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = 4'd15;

endpackage

// File: rtl/tick_period_counter.sv
// ----------------------------------------------------------------------------
// tick_period_counter
// Loadable down-counter with hold enable and zero flag. The counter parks at
// zero; the owner decides when to reload it.
// Ports:
//   clk_in        in   clock
//   rst           in   asynchronous active-high reset (count -> 0)
//   clr_i         in   synchronous clear to 0 (highest priority)
//   load_i        in   load load_val_i
//   load_val_i    in   value to load, CNT_W bits
//   en_i          in   count enable; low holds the current value
//   count_next_o  out  value the counter takes at the next edge
//   zero_o        out  current count is zero
// ----------------------------------------------------------------------------
module tick_period_counter #(
    parameter int CNT_W = 33
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_next_o,
    output logic             zero_o
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - ONE;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_next_o = count_d;
    assign zero_o       = (count_q == '0);

endmodule

// File: rtl/game_tick_sched.sv
// ----------------------------------------------------------------------------
// game_tick_sched
// Run-state controller and programmable tick scheduler. Produces a one-cycle
// tick enable every `period` RUN cycles, a blink square wave toggled on every
// tick, and shortens the interval by STEP (down to MIN_PERIOD) on each applied
// level-up.
// Optional feature: define GAME_TICK_SCHED_WARN_EN to drive `warn` during the
// last WARN_CYCLES cycles before each tick; otherwise `warn` is held at 0.
// Ports:
//   clk_in    in   clock
//   rst       in   asynchronous active-high reset
//   start     in   pulse: IDLE -> RUN
//   pause     in   pulse: toggle RUN / PAUSE
//   stop      in   pulse: any state -> IDLE
//   level_up  in   pulse: request a shorter interval at the next reload
//   tick      out  one-cycle enable per interval
//   blink     out  toggles on every tick
//   running   out  high in RUN
//   paused    out  high in PAUSE
//   level     out  applied level count, saturating at 15
//   period    out  interval currently in force
//   warn      out  pre-tick warning window
// ----------------------------------------------------------------------------
module game_tick_sched
    import game_tick_pkg::*;
#(
    parameter int unsigned BASE_PERIOD = DEF_BASE_PERIOD,
    parameter int unsigned MIN_PERIOD  = DEF_MIN_PERIOD,
    parameter int unsigned STEP        = DEF_STEP,
    parameter int unsigned WARN_CYCLES = DEF_WARN_CYCLES,
    parameter int          CNT_W       = DEF_CNT_W
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic               start,
    input  logic               pause,
    input  logic               stop,
    input  logic               level_up,
    output logic               tick,
    output logic               blink,
    output logic               running,
    output logic               paused,
    output logic [LEVEL_W-1:0] level,
    output logic [CNT_W-1:0]   period,
    output logic               warn
);

`ifdef GAME_TICK_SCHED_WARN_EN
    localparam logic WARN_EN = 1'b1;
`else
    localparam logic WARN_EN = 1'b0;
`endif

    localparam int               CW1        = CNT_W + 1;
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] BASE_P     = CNT_W'(BASE_PERIOD);
    localparam logic [CNT_W-1:0] MIN_P      = CNT_W'(MIN_PERIOD);
    localparam logic [CW1-1:0]   MIN_W      = CW1'(MIN_PERIOD);
    localparam logic [CW1-1:0]   STEP_W     = CW1'(STEP);
    localparam logic [CW1-1:0]   WARN_W     = CW1'(WARN_CYCLES);
    // A floor above the starting interval would lengthen it; keep BASE instead.
    localparam logic             FLOOR_HIGH = (MIN_PERIOD > BASE_PERIOD);

    run_state_t         state_q;
    run_state_t         state_d;
    logic               tick_q;
    logic               blink_q;
    logic               running_q;
    logic               paused_q;
    logic               warn_q;
    logic               pend_q;
    logic [LEVEL_W-1:0] level_q;
    logic [CNT_W-1:0]   period_q;

    logic               go_start;
    logic               reload;
    logic               lvl_req;
    logic               apply_lvl;
    logic [CW1-1:0]     diff_w;
    logic [CNT_W-1:0]   shrunk;
    logic [CNT_W-1:0]   new_period;
    logic [CNT_W-1:0]   load_val;
    logic [CNT_W-1:0]   cnt_next;
    logic               cnt_zero;
    logic               warn_d;

    // ---------------- next-state and control decode ----------------
    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (start) state_d = ST_RUN;
                ST_RUN:   if (pause) state_d = ST_PAUSE;
                ST_PAUSE: if (pause) state_d = ST_RUN;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    assign go_start  = (state_q == ST_IDLE) && start && !stop;
    // Reload is judged on the current state, so a pause sampled on the reload
    // edge still lets that tick out; the freeze starts with the next count.
    assign reload    = (state_q == ST_RUN) && cnt_zero && !stop;
    // A pause in the same cycle outranks the level request.
    assign lvl_req   = (state_q != ST_IDLE) && level_up && !stop && !pause;
    assign apply_lvl = reload && pend_q;

    // Extra bit catches underflow when period < STEP; both cases clamp to MIN.
    assign diff_w = {1'b0, period_q} - STEP_W;

    always_comb begin
        shrunk = diff_w[CNT_W-1:0];
        if (diff_w[CNT_W] || (diff_w < MIN_W)) begin
            shrunk = MIN_P;
        end
        if (FLOOR_HIGH) begin
            shrunk = period_q;
        end
    end

    assign new_period = apply_lvl ? shrunk : period_q;
    assign load_val   = go_start ? (BASE_P - ONE) : (new_period - ONE);

    // Warning is registered from the counter's next value so it lines up with
    // the count it describes.
    assign warn_d = WARN_EN && (state_d == ST_RUN) && ({1'b0, cnt_next} < WARN_W);

    // ---------------- interval counter ----------------
    tick_period_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk_in       (clk_in),
        .rst          (rst),
        .clr_i        (stop),
        .load_i       (go_start || reload),
        .load_val_i   (load_val),
        .en_i         (state_q == ST_RUN),
        .count_next_o (cnt_next),
        .zero_o       (cnt_zero)
    );

    // ---------------- FSM state and registered outputs ----------------
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            tick_q    <= 1'b0;
            blink_q   <= 1'b0;
            running_q <= 1'b0;
            paused_q  <= 1'b0;
            warn_q    <= 1'b0;
            pend_q    <= 1'b0;
            level_q   <= '0;
            period_q  <= BASE_P;
        end else begin
            state_q   <= state_d;
            tick_q    <= reload;
            running_q <= (state_d == ST_RUN);
            paused_q  <= (state_d == ST_PAUSE);
            warn_q    <= warn_d;
            if (stop || go_start) begin
                blink_q  <= 1'b0;
                pend_q   <= 1'b0;
                level_q  <= '0;
                period_q <= BASE_P;
            end else begin
                if (reload) begin
                    blink_q <= ~blink_q;
                end
                if (apply_lvl) begin
                    period_q <= new_period;
                    if (level_q != LEVEL_MAX) begin
                        level_q <= level_q + LEVEL_W'(1);
                    end
                end
                // A request landing on the reload edge waits for the next one.
                if (lvl_req) begin
                    pend_q <= 1'b1;
                end else if (apply_lvl) begin
                    pend_q <= 1'b0;
                end
            end
        end
    end

    assign tick    = tick_q;
    assign blink   = blink_q;
    assign running = running_q;
    assign paused  = paused_q;
    assign warn    = warn_q;
    assign level   = level_q;
    assign period  = period_q;

endmodule

// File: tb/tb_game_tick_sched.sv
// ----------------------------------------------------------------------------
// tb_game_tick_sched
// Scoreboard bench for game_tick_sched with BASE=10, MIN=4, STEP=3, WARN=2.
// Expected ticks (edge number, blink, level, period) are queued when the
// stimulus is driven; a negedge monitor pops and compares them as ticks occur.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_game_tick_sched;

    logic       clk_in = 1'b0;
    logic       rst    = 1'b1;
    logic       start  = 1'b0;
    logic       pause  = 1'b0;
    logic       stop   = 1'b0;
    logic       level_up = 1'b0;
    logic       tick;
    logic       blink;
    logic       running;
    logic       paused;
    logic [3:0] level;
    logic [7:0] period;
    logic       warn;

    int cyc = 0;
    int total = 0;
    int bad = 0;

    typedef struct {
        int   cyc;
        logic blink;
        int   level;
        int   period;
    } exp_t;

    exp_t sb_q[$];

    game_tick_sched #(
        .BASE_PERIOD (10),
        .MIN_PERIOD  (4),
        .STEP        (3),
        .WARN_CYCLES (2),
        .CNT_W       (8)
    ) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .start    (start),
        .pause    (pause),
        .stop     (stop),
        .level_up (level_up),
        .tick     (tick),
        .blink    (blink),
        .running  (running),
        .paused   (paused),
        .level    (level),
        .period   (period),
        .warn     (warn)
    );

    always #5 clk_in = ~clk_in;

    // Edge counter: after posedge N, cyc == N.
    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_exp(input int c, input logic b, input int l, input int p);
        exp_t e;
        e.cyc = c; e.blink = b; e.level = l; e.period = p;
        sb_q.push_back(e);
    endtask

    // Called at a negedge: drive for one cycle; edge_n is the sampling edge.
    task automatic drive(input logic s_i, input logic p_i, input logic st_i,
                         input logic lu_i, output int edge_n);
        start = s_i; pause = p_i; stop = st_i; level_up = lu_i;
        edge_n = cyc + 1;
        @(negedge clk_in);
        start = 1'b0; pause = 1'b0; stop = 1'b0; level_up = 1'b0;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk_in);
    endtask

    // Tick monitor
    always @(negedge clk_in) begin : mon
        exp_t e;
        while (sb_q.size() > 0 && cyc > sb_q[0].cyc) begin
            chk("tick_missing", cyc, sb_q[0].cyc);
            void'(sb_q.pop_front());
        end
        if (tick) begin
            $display("tick cyc=%0d blink=%0b level=%0d period=%0d", cyc, blink, level, period);
            if (sb_q.size() == 0) begin
                chk("tick_unexpected", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("tick_cycle", cyc, e.cyc);
                chk("tick_blink", blink, e.blink);
                chk("tick_level", level, e.level);
                chk("tick_period", period, e.period);
            end
        end
`ifndef GAME_TICK_SCHED_WARN_EN
        if (!rst) chk("warn_off", warn, 0);
`endif
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int e;
        int s2;

        // ---------------- power-on reset ----------------
        repeat (3) @(negedge clk_in);
        chk("rst_running", running, 0);
        chk("rst_paused", paused, 0);
        chk("rst_tick", tick, 0);
        chk("rst_blink", blink, 0);
        chk("rst_warn", warn, 0);
        chk("rst_level", level, 0);
        chk("rst_period", period, 10);
        rst = 1'b0;
        @(negedge clk_in);

        // ---------------- free run ----------------
        drive(1, 0, 0, 0, s);
        chk("run_running", running, 1);
        push_exp(s + 10, 1, 0, 10);
        push_exp(s + 20, 0, 0, 10);
        push_exp(s + 30, 1, 0, 10);
`ifdef GAME_TICK_SCHED_WARN_EN
        for (int c = s + 1; c <= s + 30; c++) begin
            wait_until(c);
            chk("warn_run", warn, (((c - s) % 10) == 8 || ((c - s) % 10) == 9) ? 1 : 0);
        end
`endif
        wait_until(s + 31);
        chk("run_drain", sb_q.size(), 0);
        drive(0, 0, 1, 0, e);
        chk("stop_running", running, 0);
        chk("stop_blink", blink, 0);

        // ---------------- pause ----------------
        drive(1, 0, 0, 0, s);
        push_exp(s + 17, 1, 0, 10);
        push_exp(s + 27, 0, 0, 10);
        wait_until(s + 3);
        drive(0, 1, 0, 0, e);
        chk("pause_paused", paused, 1);
        chk("pause_running", running, 0);
`ifdef GAME_TICK_SCHED_WARN_EN
        wait_until(s + 6);
        chk("warn_paused", warn, 0);
`endif
        wait_until(s + 10);
        drive(0, 1, 0, 0, e);
        chk("resume_paused", paused, 0);
        chk("resume_running", running, 1);
`ifdef GAME_TICK_SCHED_WARN_EN
        wait_until(s + 15);
        chk("warn_resume_a", warn, 1);
        wait_until(s + 16);
        chk("warn_resume_b", warn, 1);
`endif
        wait_until(s + 28);
        chk("pause_drain", sb_q.size(), 0);
        drive(0, 0, 1, 0, e);

        // ---------------- level-up ----------------
        drive(1, 0, 0, 0, s);
        push_exp(s + 10, 1, 1, 7);
        push_exp(s + 17, 0, 2, 4);
        push_exp(s + 21, 1, 3, 4);
        push_exp(s + 25, 0, 4, 4);
        push_exp(s + 29, 1, 4, 4);
        wait_until(s + 2);  drive(0, 0, 0, 1, e);
        wait_until(s + 4);  drive(0, 0, 0, 1, e);
        wait_until(s + 12); drive(0, 0, 0, 1, e);
        wait_until(s + 18); drive(0, 0, 0, 1, e);
        wait_until(s + 22); drive(0, 0, 0, 1, e);
        wait_until(s + 30);
        chk("lvl_drain", sb_q.size(), 0);
        chk("lvl_final", level, 4);
        drive(0, 0, 1, 0, e);
        chk("lvl_stop_level", level, 0);
        chk("lvl_stop_period", period, 10);

        // ---------------- stop / priority ----------------
        drive(1, 0, 1, 0, e);
        chk("prio_idle", running, 0);
        repeat (12) @(negedge clk_in);
        chk("prio_idle_hold", running, 0);
        drive(1, 0, 0, 0, s);
        wait_until(s + 1);
        drive(0, 0, 0, 1, e);
        wait_until(s + 8);
        drive(0, 0, 1, 0, e);
        chk("stop9_running", running, 0);
        chk("stop9_level", level, 0);
        wait_until(s + 15);
        // Pending request must not survive the stop.
        drive(1, 0, 0, 0, s2);
        push_exp(s2 + 10, 1, 0, 10);
        wait_until(s2 + 11);
        chk("restart_drain", sb_q.size(), 0);
        drive(0, 0, 1, 0, e);

        // ---------------- asynchronous reset mid-interval ----------------
        drive(1, 0, 0, 0, s);
        wait_until(s + 5);
        #2 rst = 1'b1;
        #1;
        chk("arst_running", running, 0);
        chk("arst_tick", tick, 0);
        chk("arst_blink", blink, 0);
        chk("arst_level", level, 0);
        chk("arst_period", period, 10);
        repeat (20) @(negedge clk_in);
        rst = 1'b0;
        @(negedge clk_in);
        chk("arst_idle", running, 0);

        repeat (5) @(negedge clk_in);
        chk("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/game_tick_sched.md
# game_tick_sched

Run-state controller and programmable tick scheduler for the LED catcher game timing path. It replaces a free-running toggled clock with a single-cycle `tick` enable in the `clk_in` domain. It sequences game timing through idle, running and paused states, and shortens the tick interval on each level-up down to a floor. Downstream LED drop and scoring logic consumes `tick`, and `blink` provides the legacy square-wave indicator.

## Interface
- `BASE_PERIOD`, 300_000_000: interval between ticks at level 0, in `clk_in` cycles (3 s at 100 MHz).
- `MIN_PERIOD`, 50_000_000: floor for the interval.
- `STEP`, 25_000_000: interval reduction per applied level-up.
- `WARN_CYCLES`, 50_000_000: pre-tick warning window length (used only with the macro).
- `CNT_W`, 33: counter/period width; must hold `BASE_PERIOD`.
- `clk_in` input 1: system clock.
- `rst` input 1: reset, asynchronous, active-high.
- `start` input 1: one-cycle pulse; begins a game from IDLE.
- `pause` input 1: one-cycle pulse; toggles RUN/PAUSE.
- `stop` input 1: one-cycle pulse; returns to IDLE from any state.
- `level_up` input 1: one-cycle pulse; requests a shorter interval.
- `tick` output 1: one-cycle enable, once per interval in RUN.
- `blink` output 1: toggles on every tick.
- `running` output 1: high in RUN.
- `paused` output 1: high in PAUSE.
- `level` output 4: applied level count, saturating at 15.
- `period` output CNT_W: interval currently in force.
- `warn` output 1: pre-tick warning window.

## Operation
- States are IDLE, RUN and PAUSE.
- IDLE -> RUN on `start`:
  - `period` <= `BASE_PERIOD`, `level` <= 0, counter <= `BASE_PERIOD`-1, `blink` <= 0.
- RUN -> PAUSE on `pause`. The counter is frozen, and `tick`/`warn` are forced low.
- PAUSE -> RUN on `pause`. Counting resumes from the frozen value.
- Any state -> IDLE on `stop`. The counter, level, pending flag and all outputs return to reset values.
- Input priority in the same cycle is `stop` > `start` > `pause` > `level_up`.
- `start` is ignored outside IDLE. `pause` and `level_up` are ignored in IDLE.
- Counting is a down-counter in RUN.
  - At 0, the block reloads `period`-1, pulses `tick` and toggles `blink`.
- `level_up` sets a pending flag, which is applied only at the next reload.
  - On reload with the flag set: `period` <= max(`period`-`STEP`, `MIN_PERIOD`), `level` <= min(`level`+1, 15), and the flag clears.
  - The reload value uses the new period.
  - Multiple requests within one interval collapse into a single application.
  - `level_up` accepted in PAUSE stays pending.
- Arithmetic:
  - The subtraction is done at CNT_W+1 bits, so underflow clamps to `MIN_PERIOD`.
  - If `MIN_PERIOD` > `BASE_PERIOD`, `period` stays at `BASE_PERIOD`.

## Timing
- Reset values:
  - State IDLE; `tick`, `blink`, `running`, `paused`, `warn` = 0.
  - `level` = 0, `period` = `BASE_PERIOD`, counter = 0.
- All outputs are registered and change only on `clk_in` rising edges.
- `running` rises one cycle after the edge that samples `start`.
- The first `tick` is high exactly `period` cycles after the edge sampling `start`. Subsequent ticks follow every `period` RUN cycles.
- Cycles spent in PAUSE extend the interval one-for-one. Every interval contains exactly `period` RUN cycles.
- `tick` is never high on two consecutive cycles unless `period` = 1.
- A `pause` sampled on the tick cycle still lets that tick complete; the freeze applies from the next count.
- `stop` sampled on any cycle suppresses any tick due in the following cycle.
- Asserting `rst` mid-interval immediately forces reset values, with no tick.

## Configuration
- Macro `GAME_TICK_SCHED_WARN_EN`.
- Defined: `warn` is high in RUN while counter < `WARN_CYCLES`, i.e. the last `WARN_CYCLES` cycles before each tick. It is low otherwise.
- Undefined: `warn` is tied 0, and the comparator and `WARN_CYCLES` are unused.

## Structure
- Shared package `game_tick_pkg`:
  - State enum (IDLE/RUN/PAUSE).
  - Default period constants.
  - Level width (4) and level saturation value (15).
- One sub-module, `tick_period_counter`: a loadable down-counter with hold enable and a zero flag, CNT_W wide. The FSM, level logic and outputs live in `game_tick_sched`.

## Test plan
Bench parameters: `BASE_PERIOD`=10, `MIN_PERIOD`=4, `STEP`=3, `WARN_CYCLES`=2.
- Reset: assert `rst` asynchronously mid-cycle -> all outputs zero, `period`=10, `level`=0. Hold for 20 cycles -> no tick.
- Run: `start` at cycle 0 -> `tick` at cycles 10, 20 and 30; `blink` reads 1, 0, 1 after each.
- Pause: `start`, then after 4 RUN cycles issue `pause`, wait 7 cycles, `pause` again -> first tick at cycle 17; next interval is 10.
- Level-up: during four consecutive intervals, issue one `level_up` mid-interval (two in the first):
  - Intervals observed: 10, 7, 4, 4, 4.
  - `level` reads 1, 2, 3, 4.
  - The double request counts once.
- Stop and priority:
  - `start` and `stop` in the same cycle in IDLE -> remains IDLE.
  - `stop` at cycle 9 after a start -> no tick at 10; `level`=0.
- Warn (macro defined): `warn` high on cycles 8-9 of each 10-cycle interval and low in PAUSE. Macro undefined -> `warn` constant 0.
